// File: rtl/fft_pkg.sv
// Shared FFT definitions: default size, bit-reversal helper and the loader state encoding.
// Used by the loader, butterfly and twiddle stages.
package fft_pkg;

    localparam int unsigned FFT_N     = 16;
    localparam int unsigned LOG2N     = $clog2(FFT_N);
    localparam int unsigned LOG2N_MAX = 10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_HOLD = 2'd2
    } fft_state_e;

    // Reverses the low 'width' bits of idx; bits above width return zero.
    function automatic logic [LOG2N_MAX-1:0] bitrev(input logic [LOG2N_MAX-1:0] idx,
                                                    input int unsigned width);
        logic [LOG2N_MAX-1:0] r;
        r = '0;
        for (int unsigned b = 0; b < LOG2N_MAX; b++) begin
            if (b < width) r[b] = idx[width-1-b];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_bitrev.sv
// Combinational W-bit index reversal, shared with the output reorder stage.
module fft_bitrev #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] i_idx,
    output logic [W-1:0] o_rev_c
);

    for (genvar b = 0; b < W; b++) begin : g_rev
        assign o_rev_c[b] = i_idx[W-1-b];
    end

endmodule

// File: rtl/fft_sample_loader.sv
// FFT input stage: writes a valid/ready sample stream into the register bank in
// bit-reversed order and holds the full frame until the core acknowledges it.
module fft_sample_loader
    import fft_pkg::*;
#(
    parameter  int unsigned N_POINTS = FFT_N,
    parameter  int unsigned DATA_W   = 16,
    localparam int unsigned ADDR_W   = $clog2(N_POINTS),
    localparam int unsigned CNT_W    = ADDR_W + 1
) (
    input  logic                clk,
    input  logic                clr_n,
    input  logic                en,
    input  logic                abort,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_data,
    output logic                in_ready,
    output logic [N_POINTS-1:0] wr_en,
    output logic [DATA_W-1:0]   wr_data,
    output logic [ADDR_W-1:0]   wr_addr,
    output logic                bank_clr,
    output logic                frame_ready,
    input  logic                frame_ack,
    output logic [CNT_W-1:0]    sample_cnt
);

    fft_state_e          r_state,       w_state_nxt;
    logic [CNT_W-1:0]    r_count,       w_count_nxt;
    logic [N_POINTS-1:0] r_wr_en,       w_wr_en_nxt;
    logic [DATA_W-1:0]   r_wr_data,     w_wr_data_nxt;
    logic [ADDR_W-1:0]   r_wr_addr,     w_wr_addr_nxt;
    logic                r_bank_clr,    w_bank_clr_nxt;
    logic                r_frame_ready, w_frame_ready_nxt;
    logic [ADDR_W-1:0]   w_rev_idx;

    fft_bitrev #(
        .W (ADDR_W)
    ) u_bitrev (
        .i_idx   (r_count[ADDR_W-1:0]),
        .o_rev_c (w_rev_idx)
    );

    // Decoded from state only so upstream never sees a combinational loop.
    assign in_ready = (r_state == ST_FILL);

    // Next-state and next-output decode; abort outranks en, which outranks normal flow.
    always_comb begin
        w_state_nxt       = r_state;
        w_count_nxt       = r_count;
        w_wr_en_nxt       = '0;
        w_wr_data_nxt     = r_wr_data;
        w_wr_addr_nxt     = r_wr_addr;
        w_bank_clr_nxt    = 1'b0;
        w_frame_ready_nxt = r_frame_ready;

        if (abort) begin
            w_state_nxt       = en ? ST_FILL : ST_IDLE;
            w_count_nxt       = '0;
            w_bank_clr_nxt    = 1'b1;
            w_frame_ready_nxt = 1'b0;
        end else if (!en) begin
            w_state_nxt       = ST_IDLE;
            w_count_nxt       = '0;
            w_bank_clr_nxt    = (r_state != ST_IDLE);
            w_frame_ready_nxt = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_state_nxt = ST_FILL;
                    w_count_nxt = '0;
                end
                ST_FILL: begin
                    if (in_valid) begin
                        w_wr_data_nxt = in_data;
                        w_wr_en_nxt   = N_POINTS'(1) << w_rev_idx;
                        w_wr_addr_nxt = w_rev_idx;
                        w_count_nxt   = r_count + CNT_W'(1);
                        if (r_count == CNT_W'(N_POINTS - 1)) w_state_nxt = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // frame_ready trails HOLD entry by one edge, aligned with the last bank capture.
                    if (frame_ack) begin
                        w_state_nxt       = ST_FILL;
                        w_count_nxt       = '0;
                        w_frame_ready_nxt = 1'b0;
                    end else begin
                        w_frame_ready_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_count_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state       <= ST_IDLE;
            r_count       <= '0;
            r_wr_en       <= '0;
            r_wr_data     <= '0;
            r_wr_addr     <= '0;
            r_bank_clr    <= 1'b0;
            r_frame_ready <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_count       <= w_count_nxt;
            r_wr_en       <= w_wr_en_nxt;
            r_wr_data     <= w_wr_data_nxt;
            r_wr_addr     <= w_wr_addr_nxt;
            r_bank_clr    <= w_bank_clr_nxt;
            r_frame_ready <= w_frame_ready_nxt;
        end
    end

    assign wr_en       = r_wr_en;
    assign wr_data     = r_wr_data;
    assign wr_addr     = r_wr_addr;
    assign bank_clr    = r_bank_clr;
    assign frame_ready = r_frame_ready;
    assign sample_cnt  = r_count;

endmodule

// File: doc/fft_sample_loader.md
# fft_sample_loader

Input stage of the FFT processor: accepts a stream of time-domain samples over a valid/ready handshake and writes each one into the N-entry sample register bank (built from positive-edge enable flops with clear). Samples land in bit-reversed order, so the bank is ready for in-place radix-2 butterflies. The block drives the bank's per-entry write enables, shared write data and bank clear. It tells the FFT core when a full frame is resident and waits for the core's acknowledge before refilling.

## Interface
- N_POINTS, 16, FFT length; power of two, 4..1024
- DATA_W, 16, sample width in bits
- clk  in  1  clock; all state updates on rising edge
- clr_n  in  1  asynchronous, active-low reset
- en  in  1  loader enable; low forces IDLE
- abort  in  1  discard the partial frame and restart filling
- in_valid  in  1  upstream sample valid
- in_data  in  DATA_W  upstream sample
- in_ready  out  1  loader can accept a sample this cycle
- wr_en  out  N_POINTS  one-hot write enable to the bank entries
- wr_data  out  DATA_W  write data, common to all bank entries
- wr_addr  out  LOG2N  bit-reversed index currently written, for debug
- bank_clr  out  1  one-cycle clear pulse to all bank entries (active-high)
- frame_ready  out  1  full frame resident in the bank
- frame_ack  in  1  FFT core has consumed the frame
- sample_cnt  out  LOG2N+1  samples written in the current frame

## Operation
- States: IDLE, FILL, HOLD.
- IDLE: in_ready=0, count=0. en=1 moves the block to FILL on the next edge.
- FILL: in_ready=1.
  - An accepted sample (in_valid & in_ready) registers wr_data<=in_data, wr_en<=1<<bitrev(count), wr_addr<=bitrev(count), and increments count.
  - With no acceptance, wr_en is 0 that cycle.
  - The acceptance with count=N_POINTS-1 moves the block to HOLD.
- HOLD: in_ready=0. frame_ready=1 from the edge where the final bank write is captured. frame_ack=1 clears frame_ready, resets count to 0 and returns to FILL on the next edge. The bank is not cleared; it is overwritten.
- bitrev(i) reverses the LOG2N low bits of i. count is LOG2N+1 bits wide and saturates at N_POINTS in HOLD.
- Priority, highest first: clr_n, then abort, then en=0, then normal operation.
- abort=1 in any state: count <- 0, bank_clr pulses high for one cycle, wr_en <- 0, frame_ready <- 0, next state FILL if en=1, otherwise IDLE.
- en=0 in FILL or HOLD: next state IDLE, count <- 0, bank_clr pulses for one cycle, frame_ready <- 0.
- frame_ack outside HOLD is ignored.
- In HOLD, in_valid is ignored (in_ready=0), including in the same cycle as frame_ack.

## Timing
- All outputs are registered except in_ready, which is decoded from state only (no combinational path from in_valid).
- Sample accepted at edge E: wr_en/wr_data are high for the cycle after E, and the bank entry captures at edge E+1.
- Final sample accepted at edge E: frame_ready rises at E+1, the same edge the bank captures it.
- Throughput: one sample per cycle while in_valid is held high. An N-point frame takes N cycles from the first acceptance to frame_ready.
- frame_ack sampled at edge A: frame_ready falls at A, and in_ready=1 in the cycle after A.
- Reset values (clr_n low, asynchronously):
  - state IDLE, count 0
  - in_ready 0, wr_en 0, wr_data 0, wr_addr 0, bank_clr 0, frame_ready 0, sample_cnt 0
- Reset mid-frame: bank contents are untouched by the loader (the bank has its own clear), and the next frame starts at index 0.

## Structure
- Package fft_pkg: LOG2N derived from N_POINTS via clog2, the bitrev function, and the state enum {IDLE, FILL, HOLD}. The package is shared with the butterfly and twiddle stages.
- One sub-module, fft_bitrev: parameterised combinational LOG2N-bit reversal, reused by the output reorder stage.

## Test plan
- N=16, en=1, continuous in_valid with data 0..15: wr_en sequence 0x0001, 0x0100, 0x0010, 0x1000, …; index 3 gives wr_addr=12. frame_ready rises 16 cycles after the first acceptance, and in_ready drops.
- In HOLD, in_valid=1 with data 0xAAAA for 5 cycles: wr_en stays 0 and sample_cnt stays 16. frame_ack for one cycle: frame_ready falls, in_ready=1 the next cycle, and the next sample writes entry 0.
- Gapped input, in_valid toggling every other cycle: wr_en fires only on accepted cycles, and frame_ready rises after the 16th acceptance (cycle 31).
- abort asserted after 7 samples: bank_clr high for exactly 1 cycle, sample_cnt=0, and the next accepted sample goes to entry 0 (wr_en=0x0001).
- clr_n pulsed low mid-FILL, asynchronously and between edges: all outputs 0 immediately, state IDLE, then FILL one edge after release with en=1.
- en dropped in HOLD with frame_ack raised in the same cycle: IDLE, bank_clr pulses once, and frame_ready goes to 0.
